// File: rtl/ram_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_lsu_pkg
// Brief    : Shared types and constants for the RAM load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package ram_lsu_pkg;

  // RAM data word width in bits
  localparam int wd_ram_p = 32;

  // Access size encoding; 2'd3 is reserved and reported as an error
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Request sequencing states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RDW  = 3'd2,
    ST_WR   = 3'd3,
    ST_RSP  = 3'd4
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/ram_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : ram_lsu_align
// Brief    : Byte-lane extraction/extension for loads and lane merge for
//            sub-word stores. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module ram_lsu_align
  import ram_lsu_pkg::*;
(
  input  logic [wd_ram_p-1:0] rd_data_i,
  input  logic [wd_ram_p-1:0] wdata_i,
  input  logic [1:0]          size_i,
  input  logic [1:0]          lane_i,
  input  logic                unsigned_i,
  output logic [wd_ram_p-1:0] load_data_o,
  output logic [wd_ram_p-1:0] merge_data_o
);

  logic [4:0]  byte_off;
  logic [4:0]  half_off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Bit offsets of the addressed byte and halfword inside the RAM word
  assign byte_off = {lane_i, 3'b000};
  assign half_off = {lane_i[1], 4'b0000};
  assign byte_sel = rd_data_i[byte_off +: 8];
  assign half_sel = rd_data_i[half_off +: 16];

  // Load path: pick the lane and sign/zero extend to a full word
  always_comb begin
    load_data_o = rd_data_i;
    case (size_i)
      SZ_B:    load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_H:    load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: load_data_o = rd_data_i;
    endcase
  end

  // Store path: overwrite only the addressed lane, keep the other bytes
  always_comb begin
    merge_data_o = rd_data_i;
    case (size_i)
      SZ_B:    merge_data_o[byte_off +: 8]  = wdata_i[7:0];
      SZ_H:    merge_data_o[half_off +: 16] = wdata_i[15:0];
      default: merge_data_o = wdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ram_lsu.sv
`default_nettype none
// ============================================================================
// Module   : ram_lsu
// Brief    : Single-outstanding load/store initiator for a word RAM with
//            separate read/write ports. Sub-word stores use read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module ram_lsu
  import ram_lsu_pkg::*;
#(
  parameter  int ram_size_p = 1024,
  localparam int wd_addr_p  = $clog2(ram_size_p)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_we,
  input  logic [1:0]           i_req_size,
  input  logic                 i_req_unsigned,
  input  logic [31:0]          i_req_addr,
  input  logic [31:0]          i_req_wdata,
  output logic                 o_rsp_valid,
  output logic [31:0]          o_rsp_rdata,
  output logic                 o_rsp_err,
  output logic [wd_addr_p-1:0] o_ram_rd_addr,
  input  logic [31:0]          i_ram_rd_data,
  output logic                 o_ram_wr_en,
  output logic [wd_addr_p-1:0] o_ram_wr_addr,
  output logic [31:0]          o_ram_wr_data
);

  lsu_state_e           state_q;
  logic                 we_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic [wd_addr_p+1:0] addr_q;      // only the in-range byte address bits are kept
  logic [31:0]          wdata_q;
  logic                 rsp_valid_q;
  logic [31:0]          rsp_rdata_q;
  logic                 rsp_err_q;
  logic [31:0]          wr_data_q;

  logic                 req_err;
  logic [31:0]          load_data;
  logic [31:0]          merge_data;

  // Classify the incoming request: bad size, misalignment or beyond the RAM
  always_comb begin
    req_err = 1'b0;
    if (i_req_size == 2'd3)                                req_err = 1'b1;
    if ((i_req_size == SZ_H) && i_req_addr[0])             req_err = 1'b1;
    if ((i_req_size == SZ_W) && (i_req_addr[1:0] != 2'd0)) req_err = 1'b1;
    if (|i_req_addr[31:wd_addr_p+2])                       req_err = 1'b1;
  end

  ram_lsu_align u_align (
    .rd_data_i    (i_ram_rd_data),
    .wdata_i      (wdata_q),
    .size_i       (size_q),
    .lane_i       (addr_q[1:0]),
    .unsigned_i   (uns_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  // Request sequencer with registered response and write-data outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_req_valid) begin
            we_q    <= i_req_we;
            size_q  <= i_req_size;
            uns_q   <= i_req_unsigned;
            addr_q  <= i_req_addr[wd_addr_p+1:0];
            wdata_q <= i_req_wdata;
            if (req_err) begin
              // Errors answer immediately and never touch the RAM
              state_q     <= ST_RSP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
            end else if (i_req_we && (i_req_size == SZ_W)) begin
              state_q   <= ST_WR;
              wr_data_q <= i_req_wdata;
            end else begin
              // Loads and sub-word stores both need the current word first
              state_q <= ST_RD;
            end
          end
        end
        ST_RD: state_q <= ST_RDW;
        ST_RDW: begin
          if (we_q) begin
            wr_data_q <= merge_data;
            state_q   <= ST_WR;
          end else begin
            rsp_rdata_q <= load_data;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_WR: begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RSP;
        end
        ST_RSP:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready   = (state_q == ST_IDLE);
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_rsp_err     = rsp_err_q;
  assign o_ram_rd_addr = addr_q[wd_addr_p+1:2];
  assign o_ram_wr_addr = addr_q[wd_addr_p+1:2];
  assign o_ram_wr_data = wr_data_q;
  // Reset in the write cycle must suppress the strobe in that same cycle
  assign o_ram_wr_en   = (state_q == ST_WR) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_ram_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_lsu
// Brief    : Directed self-checking bench for ram_lsu with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'd0;
  logic        i_req_unsigned = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [9:0]  o_ram_rd_addr;
  logic [31:0] i_ram_rd_data;
  logic        o_ram_wr_en;
  logic [9:0]  o_ram_wr_addr;
  logic [31:0] o_ram_wr_data;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  ram_lsu #(.ram_size_p(1024)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_we       (i_req_we),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_err      (o_rsp_err),
    .o_ram_rd_addr  (o_ram_rd_addr),
    .i_ram_rd_data  (i_ram_rd_data),
    .o_ram_wr_en    (o_ram_wr_en),
    .o_ram_wr_addr  (o_ram_wr_addr),
    .o_ram_wr_data  (o_ram_wr_data)
  );

  // Word RAM: synchronous write, registered read (data one cycle after address)
  always @(posedge clk) begin
    if (o_ram_wr_en) mem[o_ram_wr_addr] <= o_ram_wr_data;
    i_ram_rd_data <= mem[o_ram_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge and watch cycles N+1..N+6
  task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_rsp, input int exp_wr, input logic [9:0] exp_wa,
                         input logic [31:0] exp_wdat, input logic [31:0] exp_rdata,
                         input logic exp_err);
    int          rsp_at = 0, rsp_cnt = 0, wr_at = 0, wr_cnt = 0;
    logic [31:0] got_rdata = '0, got_wd = '0;
    logic [9:0]  got_wa = '0;
    logic        got_err = 1'b0;
    i_req_valid = 1'b1; i_req_we = we; i_req_size = sz; i_req_unsigned = uns;
    i_req_addr = addr; i_req_wdata = wd;
    chk({tag, " ready"}, 32'(o_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (o_ram_wr_en) begin wr_cnt++; wr_at = k; got_wa = o_ram_wr_addr; got_wd = o_ram_wr_data; end
      if (o_rsp_valid) begin rsp_cnt++; rsp_at = k; got_rdata = o_rsp_rdata; got_err = o_rsp_err; end
      @(negedge clk);
    end
    chk({tag, " rsp_cycle"}, 32'(rsp_at), 32'(exp_rsp));
    chk({tag, " rsp_count"}, 32'(rsp_cnt), 32'd1);
    chk({tag, " rdata"}, got_rdata, exp_rdata);
    chk({tag, " err"}, 32'(got_err), 32'(exp_err));
    chk({tag, " wr_count"}, 32'(wr_cnt), (exp_wr != 0) ? 32'd1 : 32'd0);
    if (exp_wr != 0) begin
      chk({tag, " wr_cycle"}, 32'(wr_at), 32'(exp_wr));
      chk({tag, " wr_addr"}, 32'(got_wa), 32'(exp_wa));
      chk({tag, " wr_data"}, got_wd, exp_wdat);
    end
  endtask

  initial begin
    logic [3:0]  rdy_bits;
    int          rsp1_at, rsp2_at, rsp_n, wr_at, wr_n;
    logic [31:0] rsp1_d, rsp2_d, wr_d;
    logic [9:0]  wr_a;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset ready", 32'(o_req_ready), 32'd1);
    chk("reset rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset rdata", o_rsp_rdata, 32'd0);
    chk("reset err", 32'(o_rsp_err), 32'd0);
    chk("reset wr_en", 32'(o_ram_wr_en), 32'd0);
    chk("reset rd_addr", 32'(o_ram_rd_addr), 32'd0);
    chk("reset wr_addr", 32'(o_ram_wr_addr), 32'd0);
    chk("reset wr_data", o_ram_wr_data, 32'd0);

    // Word store then loads of each size/sign
    run_req("sw10",  1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 2, 1, 10'd4, 32'hDEADBEEF, 32'h0, 0);
    run_req("lb13",  0, 2'd0, 0, 32'h13, 32'h0, 3, 0, 10'd0, 32'h0, 32'hFFFFFFDE, 0);
    run_req("lbu13", 0, 2'd0, 1, 32'h13, 32'h0, 3, 0, 10'd0, 32'h0, 32'h000000DE, 0);
    run_req("lb11",  0, 2'd0, 0, 32'h11, 32'h0, 3, 0, 10'd0, 32'h0, 32'hFFFFFFBE, 0);
    run_req("lh12",  0, 2'd1, 0, 32'h12, 32'h0, 3, 0, 10'd0, 32'h0, 32'hFFFFDEAD, 0);
    run_req("lhu10", 0, 2'd1, 1, 32'h10, 32'h0, 3, 0, 10'd0, 32'h0, 32'h0000BEEF, 0);
    run_req("lw10",  0, 2'd2, 0, 32'h10, 32'h0, 3, 0, 10'd0, 32'h0, 32'hDEADBEEF, 0);

    // Sub-word stores via read-modify-write
    run_req("sb11",  1, 2'd0, 0, 32'h11, 32'hAABBCC55, 4, 3, 10'd4, 32'hDEAD55EF, 32'h0, 0);
    run_req("lw10b", 0, 2'd2, 0, 32'h10, 32'h0, 3, 0, 10'd0, 32'h0, 32'hDEAD55EF, 0);
    run_req("sw20",  1, 2'd2, 0, 32'h20, 32'h01020304, 2, 1, 10'd8, 32'h01020304, 32'h0, 0);
    run_req("sh22",  1, 2'd1, 0, 32'h22, 32'hFFFFA5A5, 4, 3, 10'd8, 32'hA5A50304, 32'h0, 0);
    run_req("lh22",  0, 2'd1, 0, 32'h22, 32'h0, 3, 0, 10'd0, 32'h0, 32'hFFFFA5A5, 0);

    // Error requests: immediate response, no write
    run_req("err_sh11",  1, 2'd1, 0, 32'h11,   32'h1111, 1, 0, 10'd0, 32'h0, 32'h0, 1);
    run_req("err_sw12",  1, 2'd2, 0, 32'h12,   32'h2222, 1, 0, 10'd0, 32'h0, 32'h0, 1);
    run_req("err_sz3",   0, 2'd3, 0, 32'h10,   32'h0,    1, 0, 10'd0, 32'h0, 32'h0, 1);
    run_req("err_sw1000",1, 2'd2, 0, 32'h1000, 32'h12345678, 1, 0, 10'd0, 32'h0, 32'h0, 1);
    chk("err mem4", mem[4], 32'hDEAD55EF);
    run_req("lw10c", 0, 2'd2, 0, 32'h10, 32'h0, 3, 0, 10'd0, 32'h0, 32'hDEAD55EF, 0);

    // Reset asserted during the write cycle of a byte store
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'd0; i_req_unsigned = 1'b0;
    i_req_addr = 32'h10; i_req_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstwr wr_en before rst", 32'(o_ram_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstwr wr_en under rst", 32'(o_ram_wr_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstwr rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rstwr ready", 32'(o_req_ready), 32'd1);
    chk("rstwr mem4", mem[4], 32'hDEAD55EF);

    // Held valid: load then word store back to back
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_size = 2'd2; i_req_unsigned = 1'b0;
    i_req_addr = 32'h10; i_req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    i_req_we = 1'b1; i_req_addr = 32'h14; i_req_wdata = 32'hCAFEF00D;
    rdy_bits = '0; rsp1_at = 0; rsp2_at = 0; rsp_n = 0; wr_at = 0; wr_n = 0;
    rsp1_d = '0; rsp2_d = '0; wr_d = '0; wr_a = '0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= 4) rdy_bits[k-1] = o_req_ready;
      if (k == 5) i_req_valid = 1'b0;
      if (o_rsp_valid) begin
        rsp_n++;
        if (rsp_n == 1) begin rsp1_at = k; rsp1_d = o_rsp_rdata; end
        else begin rsp2_at = k; rsp2_d = o_rsp_rdata; end
      end
      if (o_ram_wr_en) begin wr_n++; wr_at = k; wr_a = o_ram_wr_addr; wr_d = o_ram_wr_data; end
      @(negedge clk);
    end
    i_req_valid = 1'b0;
    chk("b2b ready_pattern", 32'(rdy_bits), 32'b1000);
    chk("b2b rsp_count", 32'(rsp_n), 32'd2);
    chk("b2b rsp1_cycle", 32'(rsp1_at), 32'd3);
    chk("b2b rsp1_rdata", rsp1_d, 32'hDEAD55EF);
    chk("b2b rsp2_cycle", 32'(rsp2_at), 32'd6);
    chk("b2b rsp2_rdata", rsp2_d, 32'h0);
    chk("b2b wr_count", 32'(wr_n), 32'd1);
    chk("b2b wr_cycle", 32'(wr_at), 32'd5);
    chk("b2b wr_addr", 32'(wr_a), 32'd5);
    chk("b2b wr_data", wr_d, 32'hCAFEF00D);
    run_req("lw14", 0, 2'd2, 0, 32'h14, 32'h0, 3, 0, 10'd0, 32'h0, 32'hCAFEF00D, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_lsu.md
# ram_lsu

Load/store initiator that drives the read and write ports of the core's single-port-pair word RAM. It accepts byte, halfword and word requests from the pipeline and turns them into word-aligned RAM accesses. Sub-word stores use read-modify-write. Load data is lane-extracted and sign- or zero-extended. It sits between the execute stage and the data RAM, one request in flight at a time.

## Interface
Parameters:
- ram_size_p, 1024, RAM depth in 32-bit words; must match the attached RAM
- wd_addr_p, $clog2(ram_size_p), localparam, RAM word-address width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid && ready
- i_req_we  in  1  1 = store, 0 = load
- i_req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- i_req_unsigned  in  1  zero-extend loads
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-aligned
- o_rsp_valid  out  1  one-cycle response pulse, no backpressure
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors
- o_rsp_err  out  1  misaligned, illegal size or out-of-range request
- o_ram_rd_addr  out  wd_addr_p  RAM read word address
- i_ram_rd_data  in  32  RAM read data, valid one cycle after address
- o_ram_wr_en  out  1  RAM write strobe
- o_ram_wr_addr  out  wd_addr_p  RAM write word address
- o_ram_wr_data  out  32  RAM write word

## Operation
- FSM states: IDLE, RD, RDW, WR, RSP.
- o_req_ready = (state == IDLE).
- On accept, register we, size, unsigned, addr and wdata. Word index = addr[wd_addr_p+1:2]; lane = addr[1:0].
- Error if any of the following holds; error goes IDLE→RSP with err=1 and performs no RAM access:
  - size==3
  - half and addr[0]
  - word and addr[1:0]!=0
  - addr[31:wd_addr_p+2]!=0
- Load: IDLE→RD→RDW→RSP.
- Word store: IDLE→WR→RSP.
- Sub-word store: IDLE→RD→RDW→WR→RSP.
- RSP→IDLE unconditionally.
- o_ram_rd_addr and o_ram_wr_addr are always the registered word index.
- o_ram_wr_en = (state==WR) && !rst.
- RDW, load path: byte = rd_data[8*lane +: 8]; half = rd_data[16*addr[1] +: 16]. Sign-extend unless i_req_unsigned. Register the result into the response register.
- RDW, sub-word store path: merge wdata[7:0] or wdata[15:0] into the addressed lane of rd_data. All other bytes are preserved. Register the result as o_ram_wr_data.
- Word store: o_ram_wr_data = registered wdata.
- Reset values:
  - state IDLE
  - o_rsp_valid 0, o_rsp_rdata 0, o_rsp_err 0
  - o_ram_wr_en 0, both RAM addresses 0, o_ram_wr_data 0
  - o_req_ready 1 from the first cycle after reset.

## Timing
Accept at cycle N. Latencies:
- Load: rd_addr presented in N+1; data sampled in N+2; o_rsp_valid in N+3.
- Word store: wr_en in N+1; o_rsp_valid in N+2.
- Sub-word store: rd_addr in N+1; merge in N+2; wr_en in N+3; o_rsp_valid in N+4.
- Error: o_rsp_valid with err in N+1.

Other rules:
- Next accept is possible in the cycle after RSP.
- o_rsp_valid is high for exactly one cycle. o_rsp_rdata and o_rsp_err hold their values until the next response.
- o_ram_wr_en is high for exactly one cycle per store and never for loads or errors.
- Reset mid-operation aborts the request: no write, no response. If rst is asserted in a WR cycle, the write is suppressed.
- A held i_req_valid while busy is ignored; the request is accepted in the first IDLE cycle.

## Structure
- Shared package ram_lsu_pkg holds:
  - lsu_size_e: SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2
  - lsu_state_e
  - wd_ram_p = 32
- Sub-module ram_lsu_align: combinational lane extract/extend for loads and lane merge for stores, selected by size, lane and unsigned. The FSM and registers stay in ram_lsu.

## Test plan
- Word store 0xDEADBEEF to 0x10 → wr_en only in N+1, wr_addr 4, wr_data 0xDEADBEEF; rsp in N+2, err 0, rdata 0.
- Loads after that store:
  - byte 0x13 signed → 0xFFFFFFDE
  - byte 0x13 unsigned → 0x000000DE
  - half 0x12 signed → 0xFFFFDEAD
  - word 0x10 → 0xDEADBEEF
  - each response in N+3.
- Store byte 0x55 to 0x11 → single wr_en in N+3 with wr_data 0xDEAD55EF; rsp in N+4; a following word load returns 0xDEAD55EF.
- Each of the following → rsp err=1 in N+1, rdata 0, wr_en never high, RAM contents unchanged:
  - half to 0x11
  - word to 0x12
  - size 3
  - word to 0x1000 with ram_size_p=1024
- Reset asserted in the WR cycle of a byte store → wr_en low, no rsp, RAM word unchanged, o_req_ready 1 the next cycle.
- i_req_valid held high with back-to-back load then store → o_req_ready low from N+1 to N+3; second request accepted in N+4 with its own fields; both responses arrive in order.
